// File: rtl/pooyan_pkg.sv
// Shared FSM state encoding and default frame timings for the coin/start
// sequencer.
package pooyan_pkg;

    typedef logic [2:0] state_t;

    localparam state_t S_IDLE  = 3'd0;
    localparam state_t S_COIN  = 3'd1;
    localparam state_t S_GAP   = 3'd2;
    localparam state_t S_START = 3'd3;
    localparam state_t S_HOLD  = 3'd4;

    localparam int DEF_COIN_FRAMES  = 4;
    localparam int DEF_GAP_FRAMES   = 8;
    localparam int DEF_START_FRAMES = 4;
    localparam int DEF_HOLD_FRAMES  = 30;
    localparam int DEF_P2_COINS     = 2;

    function automatic int max_of(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/rise_detect.sv
// Registered 0->1 edge detector: one-cycle pulse the cycle after the input
// is first seen high.
module rise_detect (
    input  logic i_clk,
    input  logic i_reset,
    input  logic i_d,
    output logic o_rise
);

    logic r_prev;
    logic r_rise;

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_prev <= 1'b0;
            r_rise <= 1'b0;
        end else begin
            r_prev <= i_d;
            r_rise <= i_d & ~r_prev;
        end
    end

    assign o_rise = r_rise;

endmodule

// File: rtl/coin_start_seq.sv
// Frame-timed coin insert / start press sequencer driving an arcade game core
// on behalf of 1-player and 2-player start requests.
module coin_start_seq
    import pooyan_pkg::*;
#(
    parameter int COIN_FRAMES  = DEF_COIN_FRAMES,
    parameter int GAP_FRAMES   = DEF_GAP_FRAMES,
    parameter int START_FRAMES = DEF_START_FRAMES,
    parameter int HOLD_FRAMES  = DEF_HOLD_FRAMES,
    parameter int P2_COINS     = DEF_P2_COINS
) (
    input  logic       i_clk_sys,
    input  logic       i_reset,
    input  logic       i_vblank,
    input  logic       i_req_start1,
    input  logic       i_req_start2,
    output logic       o_coin1,
    output logic       o_start1,
    output logic       o_start2,
    output logic       o_busy,
    output logic [7:0] o_coins_issued
);

    localparam int MAX_FRAMES = max_of(max_of(COIN_FRAMES, GAP_FRAMES),
                                       max_of(START_FRAMES, HOLD_FRAMES));
    localparam int FW = (MAX_FRAMES > 1) ? $clog2(MAX_FRAMES) : 1;

    logic          w_tick;
    logic          w_req1_rise;
    logic          w_req2_rise;

    state_t        r_state,       w_state_d;
    logic [FW-1:0] r_frame_cnt,   w_frame_cnt_d;
    logic [FW-1:0] w_limit;
    logic          w_last_frame;
    logic          r_pend1,       w_pend1_d;
    logic          r_pend2,       w_pend2_d;
    logic          r_p2,          w_p2_d;
    logic [7:0]    r_coin_sent,   w_coin_sent_d;
    logic [7:0]    r_coin_target, w_coin_target_d;
    logic [7:0]    r_coins,       w_coins_d;
    logic          w_take1;
    logic          w_take2;

    rise_detect u_vblank_rise (
        .i_clk   (i_clk_sys),
        .i_reset (i_reset),
        .i_d     (i_vblank),
        .o_rise  (w_tick)
    );

    rise_detect u_req1_rise (
        .i_clk   (i_clk_sys),
        .i_reset (i_reset),
        .i_d     (i_req_start1),
        .o_rise  (w_req1_rise)
    );

    rise_detect u_req2_rise (
        .i_clk   (i_clk_sys),
        .i_reset (i_reset),
        .i_d     (i_req_start2),
        .o_rise  (w_req2_rise)
    );

    always_comb begin
        case (r_state)
            S_COIN:  w_limit = FW'(COIN_FRAMES - 1);
            S_GAP:   w_limit = FW'(GAP_FRAMES - 1);
            S_START: w_limit = FW'(START_FRAMES - 1);
            S_HOLD:  w_limit = FW'(HOLD_FRAMES - 1);
            default: w_limit = '0;
        endcase
    end

    assign w_last_frame = w_tick && (r_frame_cnt == w_limit);

    always_comb begin
        w_state_d       = r_state;
        w_frame_cnt_d   = r_frame_cnt;
        w_p2_d          = r_p2;
        w_coin_sent_d   = r_coin_sent;
        w_coin_target_d = r_coin_target;
        w_coins_d       = r_coins;
        w_take1         = 1'b0;
        w_take2         = 1'b0;

        // Counter restarts on every state exit so each state sees a fresh count.
        if (w_tick && r_state != S_IDLE) begin
            w_frame_cnt_d = w_last_frame ? '0 : r_frame_cnt + 1'b1;
        end

        case (r_state)
            S_IDLE: begin
                w_frame_cnt_d = '0;
                w_coin_sent_d = '0;
                if (r_pend1) begin
                    w_take1         = 1'b1;
                    w_p2_d          = 1'b0;
                    w_coin_target_d = 8'd1;
                    w_state_d       = S_COIN;
                end else if (r_pend2) begin
                    w_take2         = 1'b1;
                    w_p2_d          = 1'b1;
                    w_coin_target_d = 8'(P2_COINS);
                    w_state_d       = S_COIN;
                end
            end
            S_COIN: begin
                if (w_last_frame) begin
                    w_coin_sent_d = r_coin_sent + 8'd1;
                    w_coins_d     = r_coins + 8'd1;
                    w_state_d     = S_GAP;
                end
            end
            S_GAP: begin
                if (w_last_frame) begin
                    w_state_d = (r_coin_sent < r_coin_target) ? S_COIN : S_START;
                end
            end
            S_START: begin
                if (w_last_frame) w_state_d = S_HOLD;
            end
            S_HOLD: begin
                if (w_last_frame) w_state_d = S_IDLE;
            end
            default: w_state_d = S_IDLE;
        endcase

        w_pend1_d = w_take1 ? 1'b0 : (r_pend1 | w_req1_rise);
        w_pend2_d = w_take2 ? 1'b0 : (r_pend2 | w_req2_rise);
    end

    always_ff @(posedge i_clk_sys) begin
        if (i_reset) begin
            r_state       <= S_IDLE;
            r_frame_cnt   <= '0;
            r_pend1       <= 1'b0;
            r_pend2       <= 1'b0;
            r_p2          <= 1'b0;
            r_coin_sent   <= '0;
            r_coin_target <= '0;
            r_coins       <= '0;
        end else begin
            r_state       <= w_state_d;
            r_frame_cnt   <= w_frame_cnt_d;
            r_pend1       <= w_pend1_d;
            r_pend2       <= w_pend2_d;
            r_p2          <= w_p2_d;
            r_coin_sent   <= w_coin_sent_d;
            r_coin_target <= w_coin_target_d;
            r_coins       <= w_coins_d;
        end
    end

    assign o_coin1        = (r_state == S_COIN);
    assign o_start1       = (r_state == S_START) && !r_p2;
    assign o_start2       = (r_state == S_START) && r_p2;
    assign o_busy         = (r_state != S_IDLE);
    assign o_coins_issued = r_coins;

endmodule
